// File: rtl/cam_match_encoder.sv
// cam_match_encoder: captures a CAM match vector and streams matching row indices in ascending order
module cam_match_encoder #(
  parameter int N_ENTRIES = 128,
  parameter int IDX_W = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 match_vld,
  input  logic [N_ENTRIES-1:0] match_vec,
  output logic                 match_rdy,
  output logic                 idx_vld,
  input  logic                 idx_rdy,
  output logic [IDX_W-1:0]     idx,
  output logic                 idx_last,
  output logic                 miss,
  output logic [IDX_W:0]       match_cnt
);
  typedef enum logic [1:0] {IDLE, EMIT, MISS} state_t;
  state_t state_q, state_d;
  logic [N_ENTRIES-1:0] pending_q, pending_d, cleared;
  logic [IDX_W:0] cnt_q, cnt_d, pop;
  logic [IDX_W-1:0] low_idx;
  logic cap, acc;
  always_comb begin
    pop = '0;
    low_idx = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      pop = pop + (IDX_W+1)'(match_vec[i]);
      if (pending_q[i]) low_idx = IDX_W'(i);
    end
  end
  // pending with its lowest set bit removed; zero means the current beat is the last
  assign cleared = pending_q & (pending_q - N_ENTRIES'(1));
  assign match_rdy = state_q == IDLE;
  assign idx_vld = state_q != IDLE;
  assign idx = state_q == EMIT ? low_idx : '0;
  assign idx_last = state_q == MISS || (state_q == EMIT && cleared == '0);
  assign miss = state_q == MISS;
  assign match_cnt = cnt_q;
  assign cap = match_rdy && match_vld;
  assign acc = idx_vld && idx_rdy;
  assign state_d = cap ? (|match_vec ? EMIT : MISS) : (acc && idx_last) ? IDLE : state_q;
  assign pending_d = cap ? match_vec : (acc && state_q == EMIT) ? cleared : pending_q;
  assign cnt_d = cap ? pop : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pending_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
